// File: rtl/decode_stage.sv
// Registered MIPS instruction-decode stage with a valid/ready handshake,
// load-use and HI/LO interlocks; reserved encodings are flagged and passed on.
module decode_stage #(
  parameter int MUL_LAT      = 4,
  parameter int DIV_LAT      = 16,
  parameter int CNT_W        = 5,
  parameter bit HAS_SPECIAL2 = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_grf_we,
  output logic [4:0]  out_grf_wa,
  output logic        out_is_load,
  output logic        out_is_store,
  output logic        out_is_branch,
  output logic        out_is_jump,
  output logic        out_is_muldiv,
  output logic        out_is_div,
  output logic        out_ri_exc,
  output logic        out_syscall
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);

  typedef enum logic [1:0] {WA_NONE, WA_RT, WA_RD, WA_RA} wa_sel_t;

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op = in_instr[31:26];
  assign rs = in_instr[25:21];
  assign rt = in_instr[20:16];
  assign rd = in_instr[15:11];
  assign fn = in_instr[5:0];

  wa_sel_t    wa_sel;
  logic [4:0] dec_wa;
  logic       dec_we;
  logic       d_load;
  logic       d_store;
  logic       d_branch;
  logic       d_jump;
  logic       d_muldiv;
  logic       d_div;
  logic       d_busy_start;
  logic       d_hilo_read;
  logic       d_ri;
  logic       d_syscall;
  logic       d_rs_used;
  logic       d_rt_used;

  always_comb begin
    wa_sel       = WA_NONE;
    d_load       = 1'b0;
    d_store      = 1'b0;
    d_branch     = 1'b0;
    d_jump       = 1'b0;
    d_muldiv     = 1'b0;
    d_div        = 1'b0;
    d_busy_start = 1'b0;
    d_hilo_read  = 1'b0;
    d_ri         = 1'b0;
    d_syscall    = 1'b0;
    d_rs_used    = 1'b0;
    d_rt_used    = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03: begin
            wa_sel    = WA_RD;
            d_rt_used = 1'b1;
          end
          6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            wa_sel    = WA_RD;
            d_rs_used = 1'b1;
            d_rt_used = 1'b1;
          end
          6'h08: begin
            d_jump    = 1'b1;
            d_rs_used = 1'b1;
          end
          6'h09: begin
            d_jump    = 1'b1;
            d_rs_used = 1'b1;
            wa_sel    = WA_RD;
          end
          6'h0C: d_syscall = 1'b1;
          6'h10, 6'h12: begin
            wa_sel      = WA_RD;
            d_hilo_read = 1'b1;
          end
          6'h11, 6'h13: begin
            d_muldiv  = 1'b1;
            d_rs_used = 1'b1;
          end
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            d_muldiv     = 1'b1;
            d_busy_start = 1'b1;
            d_div        = fn[1];
            d_rs_used    = 1'b1;
            d_rt_used    = 1'b1;
          end
          default: d_ri = 1'b1;
        endcase
      end
      6'h01: begin
        if (rt == 5'd0 || rt == 5'd1) begin
          d_branch  = 1'b1;
          d_rs_used = 1'b1;
        end else begin
          d_ri = 1'b1;
        end
      end
      6'h02: d_jump = 1'b1;
      6'h03: begin
        d_jump = 1'b1;
        wa_sel = WA_RA;
      end
      6'h04, 6'h05: begin
        d_branch  = 1'b1;
        d_rs_used = 1'b1;
        d_rt_used = 1'b1;
      end
      6'h06, 6'h07: begin
        d_branch  = 1'b1;
        d_rs_used = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
        wa_sel    = WA_RT;
        d_rs_used = 1'b1;
      end
      6'h0F: wa_sel = WA_RT;
      6'h1C: begin
        case (fn)
          6'h00, 6'h01, 6'h04, 6'h05: begin
            if (HAS_SPECIAL2) begin
              d_muldiv     = 1'b1;
              d_busy_start = 1'b1;
              d_rs_used    = 1'b1;
              d_rt_used    = 1'b1;
            end else begin
              d_ri = 1'b1;
            end
          end
          default: d_ri = 1'b1;
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        d_load    = 1'b1;
        wa_sel    = WA_RT;
        d_rs_used = 1'b1;
      end
      6'h28, 6'h29, 6'h2B: begin
        d_store   = 1'b1;
        d_rs_used = 1'b1;
        d_rt_used = 1'b1;
      end
      default: d_ri = 1'b1;
    endcase
  end

  // WA_NONE resolves to 0, so a zero address covers both "no write" and "$0".
  always_comb begin
    case (wa_sel)
      WA_RT:   dec_wa = rt;
      WA_RD:   dec_wa = rd;
      WA_RA:   dec_wa = 5'd31;
      default: dec_wa = 5'd0;
    endcase
  end
  assign dec_we = (dec_wa != 5'd0);

  logic [CNT_W-1:0] busy_cnt;
  logic             held_busy_start;
  logic             stall_lu;
  logic             stall_hl;

  assign stall_lu = in_valid & out_valid & out_is_load & (out_grf_wa != 5'd0) &
                    ((d_rs_used & (rs == out_grf_wa)) | (d_rt_used & (rt == out_grf_wa)));
  assign stall_hl = in_valid & (d_hilo_read | d_muldiv) &
                    ((busy_cnt != '0) | (out_valid & out_is_muldiv));
  assign in_ready = (~out_valid | out_ready) & ~stall_lu & ~stall_hl & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_instr       <= '0;
      out_pc          <= '0;
      out_grf_we      <= 1'b0;
      out_grf_wa      <= '0;
      out_is_load     <= 1'b0;
      out_is_store    <= 1'b0;
      out_is_branch   <= 1'b0;
      out_is_jump     <= 1'b0;
      out_is_muldiv   <= 1'b0;
      out_is_div      <= 1'b0;
      out_ri_exc      <= 1'b0;
      out_syscall     <= 1'b0;
      held_busy_start <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid       <= 1'b1;
      out_instr       <= in_instr;
      out_pc          <= in_pc;
      out_grf_we      <= dec_we;
      out_grf_wa      <= dec_wa;
      out_is_load     <= d_load;
      out_is_store    <= d_store;
      out_is_branch   <= d_branch;
      out_is_jump     <= d_jump;
      out_is_muldiv   <= d_muldiv;
      out_is_div      <= d_div;
      out_ri_exc      <= d_ri;
      out_syscall     <= d_syscall;
      held_busy_start <= d_busy_start;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // The counter starts when execute takes the op, independent of flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (out_valid && out_ready && held_busy_start) begin
      busy_cnt <= out_is_div ? DIV_LOAD : MUL_LOAD;
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases with literal expectations plus a
// randomized stream checked every cycle against a transaction-level model.
module tb_decode_stage;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 16;

  localparam logic [31:0] ADDU3 = 32'h00221821;
  localparam logic [31:0] ORI4  = 32'h34040005;
  localparam logic [31:0] LW5   = 32'h8C250000;
  localparam logic [31:0] ADDU6 = 32'h00A23021;
  localparam logic [31:0] MULT  = 32'h00220018;
  localparam logic [31:0] DIVI  = 32'h0022001A;
  localparam logic [31:0] MFLO7 = 32'h00003812;
  localparam logic [31:0] RSV   = 32'hFC000000;
  localparam logic [31:0] MADD  = 32'h70220000;
  localparam logic [31:0] ADDU0 = 32'h00220021;
  localparam logic [31:0] JAL   = 32'h0C000010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic in_ready, out_valid, out_grf_we;
  logic [31:0] out_instr, out_pc;
  logic [4:0] out_grf_wa;
  logic out_is_load, out_is_store, out_is_branch, out_is_jump;
  logic out_is_muldiv, out_is_div, out_ri_exc, out_syscall;

  logic d2_valid_in = 1'b0;
  logic [31:0] d2_instr_in = MADD;
  logic d2_in_ready, d2_out_valid, d2_we;
  logic [31:0] d2_instr, d2_pc;
  logic [4:0] d2_wa;
  logic d2_ld, d2_st, d2_br, d2_jp, d2_md, d2_dv, d2_ri, d2_sc;

  always #5 clk = ~clk;

  decode_stage #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(5), .HAS_SPECIAL2(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_grf_we(out_grf_we), .out_grf_wa(out_grf_wa),
    .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_branch(out_is_branch),
    .out_is_jump(out_is_jump), .out_is_muldiv(out_is_muldiv), .out_is_div(out_is_div),
    .out_ri_exc(out_ri_exc), .out_syscall(out_syscall));

  decode_stage #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(5), .HAS_SPECIAL2(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(d2_valid_in), .in_ready(d2_in_ready),
    .in_instr(d2_instr_in), .in_pc(32'h100), .out_valid(d2_out_valid), .out_ready(1'b1),
    .out_instr(d2_instr), .out_pc(d2_pc), .out_grf_we(d2_we), .out_grf_wa(d2_wa),
    .out_is_load(d2_ld), .out_is_store(d2_st), .out_is_branch(d2_br), .out_is_jump(d2_jp),
    .out_is_muldiv(d2_md), .out_is_div(d2_dv), .out_ri_exc(d2_ri), .out_syscall(d2_sc));

  logic [77:0] dut_bundle, d2_bundle;
  assign dut_bundle = {out_instr, out_pc, out_grf_we, out_grf_wa, out_is_load, out_is_store,
                       out_is_branch, out_is_jump, out_is_muldiv, out_is_div, out_ri_exc, out_syscall};
  assign d2_bundle  = {d2_instr, d2_pc, d2_we, d2_wa, d2_ld, d2_st, d2_br, d2_jp, d2_md, d2_dv, d2_ri, d2_sc};

  int n_total = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic we;
    logic [4:0] wa;
    logic ld, st, br, jp, md, dv, ri, sc;
    logic rs_u, rt_u, hilo, busy_start;
  } dec_t;

  // Classify by instruction family, then derive every field from the family.
  function automatic dec_t dec(input logic [31:0] w, input logic [31:0] pc);
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    logic [4:0] rt = w[20:16];
    logic [4:0] rd = w[15:11];
    bit sp = (op == 6'd0);
    bit alu_r = sp && (fn inside {[6'h20:6'h27], 6'h2A, 6'h2B});
    bit sh_i = sp && (fn inside {6'h00, 6'h02, 6'h03});
    bit sh_v = sp && (fn inside {6'h04, 6'h06, 6'h07});
    bit jr = sp && fn == 6'h08;
    bit jalr = sp && fn == 6'h09;
    bit sys = sp && fn == 6'h0C;
    bit mfhl = sp && (fn inside {6'h10, 6'h12});
    bit mthl = sp && (fn inside {6'h11, 6'h13});
    bit mul = sp && (fn inside {6'h18, 6'h19});
    bit dv = sp && (fn inside {6'h1A, 6'h1B});
    bit s2 = (op == 6'h1C) && (fn inside {6'h00, 6'h01, 6'h04, 6'h05});
    bit rimm = (op == 6'h01) && (rt inside {5'd0, 5'd1});
    bit jj = op == 6'h02;
    bit jal = op == 6'h03;
    bit br2 = op inside {6'h04, 6'h05};
    bit br1 = op inside {6'h06, 6'h07};
    bit imm = op inside {[6'h08:6'h0E]};
    bit lui = op == 6'h0F;
    bit ld = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    bit st = op inside {6'h28, 6'h29, 6'h2B};
    bit known = alu_r | sh_i | sh_v | jr | jalr | sys | mfhl | mthl | mul | dv | s2 |
                rimm | jj | jal | br2 | br1 | imm | lui | ld | st;
    logic [4:0] tgt;
    dec_t d = '0;
    d.instr = w;
    d.pc = pc;
    if (!known) begin
      d.ri = 1'b1;
      return d;
    end
    if (alu_r | sh_i | sh_v | mfhl | jalr) tgt = rd;
    else if (imm | lui | ld) tgt = rt;
    else if (jal) tgt = 5'd31;
    else tgt = 5'd0;
    d.we = (tgt != 5'd0);
    d.wa = tgt;
    d.ld = ld;
    d.st = st;
    d.br = br2 | br1 | rimm;
    d.jp = jj | jal | jr | jalr;
    d.md = mul | dv | s2 | mthl;
    d.dv = dv;
    d.sc = sys;
    d.rs_u = !(jj | jal | lui | sh_i | mfhl | sys);
    d.rt_u = alu_r | sh_i | sh_v | mul | dv | s2 | br2 | st;
    d.hilo = mfhl | d.md;
    d.busy_start = mul | dv | s2;
    return d;
  endfunction

  // Model state: the held instruction and the cycle at which HI/LO frees up.
  bit m_valid = 1'b0;
  dec_t m = '0;
  longint cyc = 0;
  longint m_free = 0;

  function automatic bit exp_ready();
    dec_t n = dec(in_instr, in_pc);
    bit lu = in_valid && m_valid && m.ld && m.wa != 5'd0 &&
             ((n.rs_u && in_instr[25:21] == m.wa) || (n.rt_u && in_instr[20:16] == m.wa));
    bit hl = in_valid && n.hilo && (cyc < m_free || (m_valid && m.md));
    return (!m_valid || out_ready) && !lu && !hl && !flush;
  endfunction

  function automatic logic [77:0] bund(input dec_t d);
    return {d.instr, d.pc, d.we, d.wa, d.ld, d.st, d.br, d.jp, d.md, d.dv, d.ri, d.sc};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m <= '0;
      m_free <= 0;
    end else begin
      if (m_valid && out_ready && m.busy_start)
        m_free <= cyc + 1 + (m.dv ? DIV_LAT : MUL_LAT);
      if (flush) m_valid <= 1'b0;
      else if (in_valid && exp_ready()) begin
        m <= dec(in_instr, in_pc);
        m_valid <= 1'b1;
      end else if (out_ready) m_valid <= 1'b0;
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, exp_ready());
      chk("out_valid", out_valid, m_valid);
      if (m_valid) chk("out_bundle", dut_bundle, bund(m));
    end
  end

  logic [31:0] pc_next = 32'h0040_0000;

  task automatic send(input logic [31:0] w);
    bit ok = 1'b0;
    in_instr = w;
    in_pc = pc_next;
    pc_next += 4;
    in_valid = 1'b1;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: got no acceptance expected acceptance of %h", w);
    end
  endtask

  task automatic latency(input string name, input logic [31:0] op, input int exp_n);
    int n = -1;
    bit acc;
    send(op);
    in_instr = MFLO7;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (out_valid && out_instr == MFLO7) begin
        n = k;
        break;
      end
      acc = in_ready;
      @(posedge clk);
      #1;
      flush = (k == 1);
      if (acc) in_valid = 1'b0;
    end
    chk(name, n, exp_n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [5:0] fn = 6'($urandom);
    logic [4:0] rt = 5'($urandom_range(0, 7));
    int k = $urandom_range(0, 9);
    if (k < 4) begin
      op = 6'd0;
      fn = 6'($urandom_range(0, 47));
    end else if (k == 4) begin
      op = 6'h01;
      rt = 5'($urandom_range(0, 3));
    end else if (k == 5) begin
      op = 6'h1C;
      fn = 6'($urandom_range(0, 7));
    end else if (k < 9) op = 6'($urandom_range(0, 16));
    else op = 6'(6'h20 + $urandom_range(0, 15));
    return {op, 5'($urandom_range(0, 7)), rt, 5'($urandom_range(0, 7)), 5'($urandom), fn};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    d2_valid_in = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_outputs", {out_valid, dut_bundle}, 79'd0);
    chk("d2_reset_ready", d2_in_ready, 1'b1);
    @(posedge clk);
    #1;
    d2_valid_in = 1'b0;
    @(negedge clk);
    chk("d2_madd_valid", d2_out_valid, 1'b1);
    chk("d2_madd_ri", d2_bundle, {MADD, 32'h100, 1'b0, 5'd0, 8'b0000_0010});

    send(ADDU3);
    in_instr = ORI4;
    in_pc = pc_next;
    @(negedge clk);
    chk("addu_out", {out_valid, out_grf_we, out_grf_wa}, {1'b1, 1'b1, 5'd3});
    chk("ori_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ori_out", {out_valid, out_grf_we, out_grf_wa}, {1'b1, 1'b1, 5'd4});

    send(LW5);
    in_instr = ADDU6;
    @(negedge clk);
    chk("lu_stall", {out_valid, in_ready}, 2'b10);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lu_bubble", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lu_addu_out", {out_valid, out_grf_wa, out_instr}, {1'b1, 5'd6, ADDU6});

    latency("mult_mflo_latency", MULT, MUL_LAT + 2);
    latency("div_mflo_latency", DIVI, DIV_LAT + 2);

    send(RSV);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rsv_out", {out_valid, out_ri_exc, out_grf_we}, 3'b110);
    send(ADDU0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("addu0_out", {out_valid, out_grf_we, out_grf_wa}, {1'b1, 1'b0, 5'd0});
    send(JAL);
    in_valid = 1'b0;
    @(negedge clk);
    chk("jal_out", {out_grf_we, out_grf_wa, out_is_jump}, {1'b1, 5'd31, 1'b1});

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(ORI4);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_stable", {out_valid, out_instr, out_grf_wa}, {1'b1, ORI4, 5'd4});
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_kill", out_valid, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 3000; i++) begin
      flush = ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = rand_instr();
      in_pc = $urandom;
      if (i == 1500) begin
        #1 rst_n = 1'b0;
        #1 chk("async_reset", {out_valid, dut_bundle}, 79'd0);
        #1 rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
